booth_mult_seq: RTL

//  Parametrised sequential radix-2 Booth multiplier, signed or unsigned per operation.

---
 rtl/booth_mult_pkg.sv | 18 +
 rtl/booth_mult_seq_step.sv | 31 +++
 rtl/booth_mult_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Build option: BOOTH_MULT_ZERO_SKIP_EN (skips iteration on zero operands).
package booth_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth iteration: add/sub on the upper half, then
// arithmetic shift of the whole partial product.
import booth_mult_pkg::*;

module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] p_i,
  input  logic               lost_i,
  input  logic [WIDTH:0]     a_i,
  output logic [2*WIDTH+1:0] p_o,
  output logic               lost_o
);

  localparam int PW = 2 * WIDTH + 2;

  logic [WIDTH:0] hi_sum;

  // Booth recode on {P[0], lostbit}, then shift right by one.
  always_comb begin
    hi_sum = p_i[PW-1:WIDTH+1];
    unique case ({p_i[0], lost_i})
      OP_ADD:  hi_sum = p_i[PW-1:WIDTH+1] + a_i;
      OP_SUB:  hi_sum = p_i[PW-1:WIDTH+1] - a_i;
      default: hi_sum = p_i[PW-1:WIDTH+1];
    endcase
    p_o    = {hi_sum[WIDTH], hi_sum, p_i[WIDTH:1]};
    lost_o = p_i[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per op.
// Build option: BOOTH_MULT_ZERO_SKIP_EN (zero operand -> done in 1 edge).
import booth_mult_pkg::*;

module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH + 2;

  mult_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0] a_q, a_d;
  logic [PW-1:0]  p_q, p_d;
  logic           lost_q, lost_d;
  logic           done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [PW-1:0]  step_p;
  logic           step_lost;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic           zero_op;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_i    (p_q),
    .lost_i (lost_q),
    .a_i    (a_q),
    .p_o    (step_p),
    .lost_o (step_lost)
  );

  // Operand extension by one bit keeps the most-negative value exact.
  always_comb begin
    a_ext   = {is_signed & operand_a[WIDTH-1], operand_a};
    b_ext   = {is_signed & operand_b[WIDTH-1], operand_b};
    zero_op = (operand_a == '0) || (operand_b == '0);
  end

  // Next-state, datapath load/step and output register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    lost_d  = lost_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a_ext;
          p_d     = {{(WIDTH+1){1'b0}}, b_ext};
          lost_d  = 1'b0;
          cnt_d   = CW'(WIDTH + 1);
          state_d = ST_RUN;
`ifdef BOOTH_MULT_ZERO_SKIP_EN
          if (zero_op) begin
            cnt_d   = '0;
            state_d = ST_DONE;
            done_d  = 1'b1;
            hi_d    = '0;
            lo_d    = '0;
          end
`endif
        end
      end
      ST_RUN: begin
        p_d    = step_p;
        lost_d = step_lost;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          hi_d    = step_p[2*WIDTH-1:WIDTH];
          lo_d    = step_p[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      lost_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      lost_q  <= lost_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Zero-skip leaves zero_op unused in the default build.
  logic unused_zero;
  assign unused_zero = zero_op;

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
